// File: rtl/vic_sched.sv
// Vectored interrupt scheduler: synchronised per-source edge/level detection, fixed-priority
// selection, a nesting stack of accepted vectors and a registered IRQ handshake FSM.
module vic_sched #(
    parameter int unsigned NSRC  = 31,
    parameter int unsigned DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NSRC-1:0] i_ext,
    input  logic            i_en,
    input  logic            i_cfg_we,
    input  logic [4:0]      i_cfg_sel,
    input  logic [3:0]      i_cfg_data,
    input  logic            i_ack,
    input  logic            i_eoi,
    output logic            o_IRQ,
    output logic [4:0]      o_irq_addr,
    output logic [2:0]      o_depth,
    output logic            o_ovf
);

    localparam logic [2:0] DepthMax = 3'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

    state_e          state_q, state_d;
    logic [NSRC-1:0] sync1_q, sync2_q, sync3_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] rise, fall, edge_m, lvl_m, pending, clr;
    logic [3:0]      cfg_q [NSRC];
    logic [3:0]      cfg_d [NSRC];
    logic [4:0]      stk_q [8];
    logic [4:0]      stk_d [8];
    logic            irq_q, irq_d;
    logic [4:0]      addr_q, addr_d;
    logic [2:0]      depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic [4:0]      cand, top;
    logic            cand_vld, deliv, ack_take;

    assign rise = sync2_q & ~sync3_q;
    assign fall = ~sync2_q & sync3_q;

    // Selects >= NSRC never match any index, so such writes fall through untouched.
    always_comb begin
        for (int i = 0; i < int'(NSRC); i++) begin
            cfg_d[i] = cfg_q[i];
            if (i_cfg_we && i_cfg_sel == 5'(i)) cfg_d[i] = i_cfg_data;
        end
    end

    // Edge sources latch; level sources follow the synced line directly. Set beats ack-clear.
    always_comb begin
        for (int i = 0; i < int'(NSRC); i++) begin
            edge_m[i]  = cfg_q[i][3] & (cfg_q[i][2] | cfg_q[i][1]);
            lvl_m[i]   = (cfg_q[i][3:1] == 3'b100);
            pend_d[i]  = edge_m[i] & ((pend_q[i] & ~clr[i]) |
                                      (cfg_q[i][2] & rise[i]) | (cfg_q[i][1] & fall[i]));
            pending[i] = edge_m[i] ? pend_q[i] : (lvl_m[i] & (sync2_q[i] == cfg_q[i][0]));
        end
    end

    always_comb begin
        cand     = 5'd0;
        cand_vld = 1'b0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                cand     = 5'(i);
                cand_vld = 1'b1;
            end
        end
    end

    assign top      = stk_q[depth_q - 3'd1];
    assign deliv    = cand_vld && i_en && (depth_q < DepthMax) &&
                      ((depth_q == 3'd0) || (cand < top));
    assign ack_take = (state_q == StReq) && i_ack && !i_eoi && (depth_q < DepthMax);

    always_comb begin
        for (int i = 0; i < int'(NSRC); i++) clr[i] = ack_take && (addr_q == 5'(i));
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        addr_d  = addr_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        for (int i = 0; i < 8; i++) stk_d[i] = stk_q[i];
        case (state_q)
            StIdle: begin
                if (deliv) begin
                    state_d = StReq;
                    irq_d   = 1'b1;
                    addr_d  = cand;
                end
            end
            StReq: begin
                if (ack_take) begin
                    state_d        = StGap;
                    irq_d          = 1'b0;
                    stk_d[depth_q] = addr_q;
                    depth_d        = depth_q + 3'd1;
                end else if (deliv) begin
                    addr_d = cand;
                end else begin
                    state_d = StIdle;
                    irq_d   = 1'b0;
                end
            end
            StGap: begin
                state_d = StIdle;
                irq_d   = 1'b0;
            end
            default: begin
                state_d = StIdle;
                irq_d   = 1'b0;
            end
        endcase
        if (state_q == StReq && i_ack && !i_eoi && depth_q == DepthMax) ovf_d = 1'b1;
        // Pop has priority; a simultaneous ack was already suppressed via ack_take.
        if (i_eoi) begin
            if (depth_q != 3'd0) depth_d = depth_q - 3'd1;
            else                 ovf_d   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
            addr_q  <= 5'd0;
            depth_q <= 3'd0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < int'(NSRC); i++) cfg_q[i] <= 4'd0;
            for (int i = 0; i < 8; i++) stk_q[i] <= 5'd0;
        end else begin
            state_q <= state_d;
            sync1_q <= i_ext;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            addr_q  <= addr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            cfg_q   <= cfg_d;
            stk_q   <= stk_d;
        end
    end

    assign o_IRQ      = irq_q;
    assign o_irq_addr = addr_q;
    assign o_depth    = depth_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_vic_sched.sv
// Self-checking bench for vic_sched: expected vectors are queued as stimulus is applied and
// compared when the DUT raises its request.
module tb_vic_sched;

    logic        clk;
    logic        rst;
    logic [30:0] ext;
    logic        en;
    logic        cfg_we;
    logic [4:0]  cfg_sel;
    logic [3:0]  cfg_data;
    logic        ack;
    logic        eoi;
    logic        irq;
    logic [4:0]  addr;
    logic [2:0]  depth;
    logic        ovf;

    int          checks;
    int          failures;
    logic [4:0]  exp_q[$];
    logic [4:0]  exp;
    bit          seen;
    int          hits;

    vic_sched #(.NSRC(31), .DEPTH(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ext      (ext),
        .i_en       (en),
        .i_cfg_we   (cfg_we),
        .i_cfg_sel  (cfg_sel),
        .i_cfg_data (cfg_data),
        .i_ack      (ack),
        .i_eoi      (eoi),
        .o_IRQ      (irq),
        .o_irq_addr (addr),
        .o_depth    (depth),
        .o_ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int sel, input logic [3:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = 5'(sel);
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic wait_irq(input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (irq === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic count_irq(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (irq !== 1'b0) cnt++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({irq, addr, depth, ovf} !== 10'd0) begin
            failures++;
            $display("FAIL reset: irq=%b addr=%0d depth=%0d ovf=%b, required all 0",
                     irq, addr, depth, ovf);
        end
    endtask

    task automatic test_edge_latency();
        do_cfg(5, 4'b1100);
        exp_q.push_back(5'd5);
        ext[5] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (irq !== 1'b0) begin
                failures++;
                $display("FAIL latency_early: cycle %0d irq=%b, required 0", k, irq);
            end
        end
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (irq !== 1'b1 || addr !== exp) begin
            failures++;
            $display("FAIL latency_offer: irq=%b addr=%0d, required irq=1 addr=%0d", irq, addr, exp);
        end
        do_ack();
        checks++;
        if (depth !== 3'd1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL ack_push: depth=%0d irq=%b, required depth=1 irq=0", depth, irq);
        end
        do_eoi();
        count_irq(8, hits);
        checks++;
        if (hits !== 0 || depth !== 3'd0) begin
            failures++;
            $display("FAIL no_rerequest: irq cycles=%0d depth=%0d, required 0 and 0", hits, depth);
        end
        ext[5] = 1'b0;
    endtask

    task automatic test_priority();
        do_cfg(3, 4'b1100);
        do_cfg(9, 4'b1100);
        exp_q.push_back(5'd3);
        ext[3] = 1'b1;
        ext[9] = 1'b1;
        wait_irq(20, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || addr !== exp) begin
            failures++;
            $display("FAIL prio_offer: seen=%b addr=%0d, required addr=%0d", seen, addr, exp);
        end
        do_ack();
        count_irq(8, hits);
        checks++;
        if (hits !== 0) begin
            failures++;
            $display("FAIL prio_block: irq cycles=%0d while 3 in service, required 0", hits);
        end
        exp_q.push_back(5'd9);
        do_eoi();
        wait_irq(20, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || addr !== exp) begin
            failures++;
            $display("FAIL prio_after_eoi: seen=%b addr=%0d, required addr=%0d", seen, addr, exp);
        end
        do_ack();
        do_eoi();
        ext[3] = 1'b0;
        ext[9] = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_nesting();
        do_cfg(2, 4'b1100);
        exp_q.push_back(5'd9);
        ext[9] = 1'b1;
        wait_irq(20, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || addr !== exp) begin
            failures++;
            $display("FAIL nest_outer: seen=%b addr=%0d, required addr=%0d", seen, addr, exp);
        end
        do_ack();
        exp_q.push_back(5'd2);
        ext[2] = 1'b1;
        wait_irq(20, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || addr !== exp) begin
            failures++;
            $display("FAIL nest_inner: seen=%b addr=%0d, required addr=%0d", seen, addr, exp);
        end
        do_ack();
        checks++;
        if (depth !== 3'd2) begin
            failures++;
            $display("FAIL nest_depth: depth=%0d, required 2", depth);
        end
        do_eoi();
        do_eoi();
        checks++;
        if (depth !== 3'd0) begin
            failures++;
            $display("FAIL nest_unwind: depth=%0d, required 0", depth);
        end
        ext[2] = 1'b0;
        ext[9] = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_ack_eoi_same();
        exp_q.push_back(5'd9);
        ext[9] = 1'b1;
        wait_irq(20, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || addr !== exp) begin
            failures++;
            $display("FAIL same_outer: seen=%b addr=%0d, required addr=%0d", seen, addr, exp);
        end
        do_ack();
        ext[2] = 1'b1;
        wait_irq(20, seen);
        ack = 1'b1;
        eoi = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b0;
        checks++;
        if (!seen || depth !== 3'd0 || irq !== 1'b1 || addr !== 5'd2) begin
            failures++;
            $display("FAIL ack_eoi_same: depth=%0d irq=%b addr=%0d, required depth=0 irq=1 addr=2",
                     depth, irq, addr);
        end
        do_ack();
        do_eoi();
        ext[2] = 1'b0;
        ext[9] = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_full_stack();
        logic [4:0] srcs [4];
        srcs[0] = 5'd10;
        srcs[1] = 5'd7;
        srcs[2] = 5'd4;
        srcs[3] = 5'd1;
        do_cfg(0, 4'b1100);
        for (int j = 0; j < 4; j++) begin
            do_cfg(int'(srcs[j]), 4'b1100);
            exp_q.push_back(srcs[j]);
            ext[srcs[j]] = 1'b1;
            wait_irq(20, seen);
            exp = exp_q.pop_front();
            checks++;
            if (!seen || addr !== exp) begin
                failures++;
                $display("FAIL fill_%0d: seen=%b addr=%0d, required addr=%0d", j, seen, addr, exp);
            end
            do_ack();
        end
        checks++;
        if (depth !== 3'd4) begin
            failures++;
            $display("FAIL full_depth: depth=%0d, required 4", depth);
        end
        ext[0] = 1'b1;
        count_irq(10, hits);
        checks++;
        if (hits !== 0) begin
            failures++;
            $display("FAIL full_block: irq cycles=%0d with stack full, required 0", hits);
        end
        exp_q.push_back(5'd0);
        do_eoi();
        wait_irq(20, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || addr !== exp) begin
            failures++;
            $display("FAIL full_release: seen=%b addr=%0d, required addr=%0d", seen, addr, exp);
        end
        do_ack();
        for (int j = 0; j < 4; j++) do_eoi();
        checks++;
        if (depth !== 3'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL full_unwind: depth=%0d ovf=%b, required 0 and 0", depth, ovf);
        end
        ext = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_level();
        do_cfg(6, 4'b1001);
        exp_q.push_back(5'd6);
        ext[6] = 1'b1;
        wait_irq(20, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || addr !== exp) begin
            failures++;
            $display("FAIL level_offer: seen=%b addr=%0d, required addr=%0d", seen, addr, exp);
        end
        do_ack();
        count_irq(6, hits);
        checks++;
        if (hits !== 0) begin
            failures++;
            $display("FAIL level_in_service: irq cycles=%0d, required 0", hits);
        end
        exp_q.push_back(5'd6);
        do_eoi();
        wait_irq(20, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || addr !== exp) begin
            failures++;
            $display("FAIL level_redeliver: seen=%b addr=%0d, required addr=%0d", seen, addr, exp);
        end
        do_ack();
        ext[6] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        do_eoi();
        count_irq(8, hits);
        checks++;
        if (hits !== 0 || depth !== 3'd0) begin
            failures++;
            $display("FAIL level_quiet: irq cycles=%0d depth=%0d, required 0 and 0", hits, depth);
        end
        ext[6] = 1'b1;
        wait_irq(20, seen);
        ext[6] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (!seen || irq !== 1'b0 || depth !== 3'd0) begin
            failures++;
            $display("FAIL level_withdraw: seen=%b irq=%b depth=%0d, required seen=1 irq=0 depth=0",
                     seen, irq, depth);
        end
        do_cfg(6, 4'b0000);
    endtask

    task automatic test_ovf();
        do_ack();
        checks++;
        if (depth !== 3'd0 || irq !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ack_idle: depth=%0d irq=%b ovf=%b, required 0 0 0", depth, irq, ovf);
        end
        do_eoi();
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (ovf !== 1'b1 || depth !== 3'd0) begin
            failures++;
            $display("FAIL ovf_sticky: ovf=%b depth=%0d, required ovf=1 depth=0", ovf, depth);
        end
    endtask

    task automatic test_reset_mid();
        do_cfg(12, 4'b1100);
        ext[12] = 1'b1;
        wait_irq(20, seen);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (!seen || {irq, addr, depth, ovf} !== 10'd0) begin
            failures++;
            $display("FAIL reset_mid: seen=%b irq=%b addr=%0d depth=%0d ovf=%b, required seen=1 rest 0",
                     seen, irq, addr, depth, ovf);
        end
        tick();
        tick();
        rst = 1'b1;
        ext[12] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        ext[12] = 1'b1;
        count_irq(10, hits);
        checks++;
        if (hits !== 0) begin
            failures++;
            $display("FAIL reset_cfg_cleared: irq cycles=%0d after reset, required 0", hits);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        ext      = '0;
        en       = 1'b0;
        cfg_we   = 1'b0;
        cfg_sel  = 5'd0;
        cfg_data = 4'd0;
        ack      = 1'b0;
        eoi      = 1'b0;
        tick();
        tick();
        test_reset();
        rst = 1'b1;
        en  = 1'b1;
        tick();
        test_edge_latency();
        test_priority();
        test_nesting();
        test_ack_eoi_same();
        test_full_stack();
        test_level();
        test_ovf();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
